musk_mem_responder: RTL and testbench

- MUSKBUS target end: accepts line requests from a core's fetch/load path, acknowledges them, and returns or absorbs 64-byte lines as 8 x 64-bit beats.
- Backed by an internal word-addressed memory array.
- Sits between the core's MUSKBUS port and simulation/top-level memory; serves one request at a time.

---
 rtl/musk_mem_responder_pkg.sv | 50 +++++
 rtl/musk_mem_responder_mem_array.sv | 33 +++
 rtl/musk_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_musk_mem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/musk_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : musk_mem_responder_pkg
// Description : MUSKBUS field layouts, op/target codes, line geometry and the
//               responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package musk_mem_responder_pkg;

  localparam int c_WORD_W         = 64;
  localparam int c_LINE_BYTES     = 64;
  localparam int c_BEATS_PER_LINE = 8;
  localparam int c_BEAT_W         = $clog2(c_BEATS_PER_LINE);
  localparam int c_LINE_LSB       = $clog2(c_LINE_BYTES);

  localparam logic       c_OP_READ    = 1'b1;
  localparam logic       c_OP_WRITE   = 1'b0;
  localparam logic [3:0] c_TGT_MEMORY = 4'h1;

  localparam logic [c_WORD_W-1:0] c_OOB_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic       op;
    logic [3:0] target;
    logic [7:0] id;
  } tag_t;

  typedef struct packed {
    logic                reqcyc;
    logic [c_WORD_W-1:0] req;
    tag_t                reqtag;
  } req_t;

  typedef struct packed {
    logic                respcyc;
    logic [c_WORD_W-1:0] resp;
    tag_t                resptag;
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_RLAT  = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4,
    ST_WDONE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/musk_mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : musk_mem_array
// Description : Single-port 64-bit word store, synchronous write and
//               combinational read, addressed as {line, beat}.
// Revision    : 1.0 - initial release
// ============================================================================
module musk_mem_array
  import musk_mem_responder_pkg::*;
#(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [c_WORD_W-1:0] wdata,
  output logic [c_WORD_W-1:0] rdata
);

  // No reset: contents survive a responder reset by design.
  logic [c_WORD_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/musk_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : musk_mem_responder
// Description : MUSKBUS memory target; serves one 64-byte line request at a
//               time as 8 x 64-bit beats. Define MUSK_MEM_BOUNDS_CHECK_EN to
//               flag out-of-range lines instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
module musk_mem_responder
  import musk_mem_responder_pkg::*;
#(
  parameter int         MEM_LINES  = 1024,
  parameter int         RD_LATENCY = 4,
  parameter logic [3:0] TARGET_ID  = c_TGT_MEMORY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_reqcyc,
  input  logic [63:0] req_req,
  input  logic [12:0] req_reqtag,
  output logic        reqack,
  output logic        resp_respcyc,
  output logic [63:0] resp_resp,
  output logic [12:0] resp_resptag,
  input  logic        respack
);

  localparam int c_IDX_W  = $clog2(MEM_LINES);
  localparam int c_LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int c_ADDR_W = c_IDX_W + c_BEAT_W;
  localparam logic [c_LAT_W-1:0]  c_LAT_LOAD = c_LAT_W'(RD_LATENCY - 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS_PER_LINE - 1);

  state_t              r_state, w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx,   w_idx_nxt;
  tag_t                r_tag,   w_tag_nxt;
  logic [c_BEAT_W-1:0] r_beat,  w_beat_nxt;
  logic [c_LAT_W-1:0]  r_lat,   w_lat_nxt;
  logic                r_oob,   w_oob_nxt;

  tag_t                w_req_tag;
  tag_t                w_resp_tag;
  logic                w_req_oob;
  logic                w_mem_we;
  logic [c_WORD_W-1:0] w_mem_rdata;
  logic                w_unused;

  assign w_req_tag = tag_t'(req_reqtag);

`ifdef MUSK_MEM_BOUNDS_CHECK_EN
  assign w_req_oob = |req_req[63:c_LINE_LSB+c_IDX_W];
`else
  assign w_req_oob = 1'b0;
`endif

  // Out-of-range transfers report the error by flipping the op bit of the tag.
  assign w_resp_tag = {r_tag.op ^ r_oob, r_tag.target, r_tag.id};

  assign w_unused = ^{req_req[c_LINE_LSB-1:0], req_req[63:c_LINE_LSB+c_IDX_W]};

  musk_mem_array #(
    .DEPTH  (MEM_LINES * c_BEATS_PER_LINE),
    .ADDR_W (c_ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  ({r_idx, r_beat}),
    .wdata (req_req),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_tag   <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_oob   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tag   <= w_tag_nxt;
      r_beat  <= w_beat_nxt;
      r_lat   <= w_lat_nxt;
      r_oob   <= w_oob_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_tag_nxt    = r_tag;
    w_beat_nxt   = r_beat;
    w_lat_nxt    = r_lat;
    w_oob_nxt    = r_oob;
    w_mem_we     = 1'b0;
    reqack       = 1'b0;
    resp_respcyc = 1'b0;
    resp_resp    = '0;
    resp_resptag = '0;

    case (r_state)
      ST_IDLE: begin
        if (req_reqcyc && (w_req_tag.target == TARGET_ID)) begin
          w_idx_nxt   = req_req[c_LINE_LSB +: c_IDX_W];
          w_tag_nxt   = w_req_tag;
          w_oob_nxt   = w_req_oob;
          w_state_nxt = ST_ACK;
        end
      end

      ST_ACK: begin
        reqack     = 1'b1;
        w_beat_nxt = '0;
        if (r_tag.op == c_OP_READ) begin
          // ACK itself is the first latency cycle, so RLAT runs RD_LATENCY-1 cycles.
          w_lat_nxt   = c_LAT_LOAD;
          w_state_nxt = (RD_LATENCY == 1) ? ST_RDATA : ST_RLAT;
        end else begin
          w_state_nxt = ST_WDATA;
        end
      end

      ST_RLAT: begin
        w_lat_nxt = r_lat - 1'b1;
        if (r_lat <= c_LAT_W'(1)) begin
          w_state_nxt = ST_RDATA;
        end
      end

      ST_RDATA: begin
        resp_respcyc = 1'b1;
        resp_resp    = r_oob ? c_OOB_DATA : w_mem_rdata;
        resp_resptag = w_resp_tag;
        if (respack) begin
          w_beat_nxt = r_beat + 1'b1;
          if (r_beat == c_LAST_BEAT) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_WDATA: begin
        if (req_reqcyc) begin
          w_mem_we   = !r_oob;
          w_beat_nxt = r_beat + 1'b1;
          if (r_beat == c_LAST_BEAT) begin
            w_state_nxt = ST_WDONE;
          end
        end
      end

      ST_WDONE: begin
        resp_respcyc = 1'b1;
        resp_resptag = w_resp_tag;
        if (respack) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_musk_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_musk_mem_responder
// Description : Self-checking bench for musk_mem_responder with a line-level
//               reference model (honours MUSK_MEM_BOUNDS_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_musk_mem_responder;

  localparam int          MEM_LINES  = 1024;
  localparam int          RD_LATENCY = 4;
  localparam logic [63:0] c_DEAD     = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef MUSK_MEM_BOUNDS_CHECK_EN
  localparam bit c_BOUNDS = 1'b1;
`else
  localparam bit c_BOUNDS = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        req_reqcyc = 1'b0;
  logic [63:0] req_req    = '0;
  logic [12:0] req_reqtag = '0;
  logic        respack    = 1'b0;
  logic        reqack;
  logic        resp_respcyc;
  logic [63:0] resp_resp;
  logic [12:0] resp_resptag;

  always #5 clk = ~clk;

  musk_mem_responder #(
    .MEM_LINES  (MEM_LINES),
    .RD_LATENCY (RD_LATENCY),
    .TARGET_ID  (4'h1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_reqcyc   (req_reqcyc),
    .req_req      (req_req),
    .req_reqtag   (req_reqtag),
    .reqack       (reqack),
    .resp_respcyc (resp_respcyc),
    .resp_resp    (resp_resp),
    .resp_resptag (resp_resptag),
    .respack      (respack)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [12:0] t;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] model_mem [int];
  int          tests = 0;
  int          fails = 0;
  int          ack_mode = 0;
  logic [63:0] cap_d [8];
  logic [12:0] cap_t;
  int          cap_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: line = addr/64, wrapped modulo MEM_LINES unless bounds-checked.
  function automatic bit is_oob(input logic [63:0] addr);
    return c_BOUNDS && ((addr >> 6) >= 64'(MEM_LINES));
  endfunction

  function automatic int word_key(input logic [63:0] addr, input int b);
    return int'(((addr >> 6) % 64'(MEM_LINES)) * 64'd8) + b;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [63:0] addr, input int b);
    if (is_oob(addr)) return c_DEAD;
    return model_mem[word_key(addr, b)];
  endfunction

  function automatic logic [12:0] exp_tag(input bit op, input logic [7:0] id, input logic [63:0] addr);
    return {op ^ is_oob(addr), 4'h1, id};
  endfunction

  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ack_mode)
        0:       respack = 1'b1;
        1:       respack = (cyc % 3 == 0);
        default: respack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Single compare process: every valid response beat against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && resp_respcyc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(resp_respcyc), 64'd0);
        end else begin
          chk("resp_data", resp_resp, exp_q[0].d);
          chk("resp_tag", 64'(resp_resptag), 64'(exp_q[0].t));
          if (respack) begin
            if (cap_n < 8) cap_d[cap_n] = resp_resp;
            cap_t = resp_resptag;
            cap_n++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_cmd(input bit op, input logic [63:0] addr, input logic [7:0] id,
                        input logic [3:0] tgt, output int n_ack, output int q_at_ack);
    bit acked;
    acked    = 1'b0;
    n_ack    = 0;
    q_at_ack = -1;
    req_reqcyc = 1'b1;
    req_req    = addr;
    req_reqtag = {op, tgt, id};
    while (!acked && n_ack < 400) begin
      @(posedge clk);
      #1;
      n_ack++;
      if (reqack) begin
        acked    = 1'b1;
        q_at_ack = exp_q.size();
      end
    end
    chk("cmd_acked", 64'(acked), 64'd1);
    if (acked) begin
      @(posedge clk);
      #1;
    end
    req_reqcyc = 1'b0;
    req_req    = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("idle_after", 64'(resp_respcyc), 64'd0);
  endtask

  task automatic read_txn(input logic [63:0] addr, input logic [7:0] id, output int n_ack, output int lat);
    int qa;
    cap_n = 0;
    do_cmd(1'b1, addr, id, 4'h1, n_ack, qa);
    for (int b = 0; b < 8; b++) exp_q.push_back('{d: exp_rd(addr, b), t: exp_tag(1'b1, id, addr)});
    lat = n_ack + 1;
    while (!resp_respcyc && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    drain();
  endtask

  task automatic write_txn(input logic [63:0] addr, input logic [7:0] id, input logic [63:0] d [8],
                           input int gap_at, input int gap_len);
    int na, qa;
    cap_n = 0;
    do_cmd(1'b0, addr, id, 4'h1, na, qa);
    for (int b = 0; b < 8; b++) begin
      req_reqcyc = 1'b1;
      req_req    = d[b];
      @(posedge clk);
      #1;
      if (!is_oob(addr)) model_mem[word_key(addr, b)] = d[b];
      if (b == gap_at && b < 7) begin
        for (int g = 0; g < gap_len; g++) begin
          req_reqcyc = 1'b0;
          req_req    = {$urandom, $urandom};
          @(posedge clk);
          #1;
        end
      end
    end
    req_reqcyc = 1'b0;
    exp_q.push_back('{d: 64'd0, t: exp_tag(1'b0, id, addr)});
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d [8];
    logic [63:0] addr;
    int          na, qa, lat, seen, n, idx;
    int          lines[$];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_reqack", 64'(reqack), 64'd0);
    chk("rst_respcyc", 64'(resp_respcyc), 64'd0);
    chk("rst_resp", resp_resp, 64'd0);
    chk("rst_resptag", 64'(resp_resptag), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int b = 0; b < 8; b++) d[b] = 64'h300 + 64'(b);
    write_txn(64'h0, 8'h01, d, 7, 0);
    for (int b = 0; b < 8; b++) d[b] = 64'h200 + 64'(b);
    write_txn(64'h80, 8'h02, d, 7, 0);
    lines = '{0, 2};

    read_txn(64'h80, 8'h05, na, lat);
    chk("rd_ack_delay", 64'(na), 64'd1);
    chk("rd_first_beat", 64'(lat), 64'(RD_LATENCY + 1));
    chk("rd_beats", 64'(cap_n), 64'd8);
    for (int b = 0; b < 8; b++) chk("rd_line2_lit", cap_d[b], 64'h200 + 64'(b));
    chk("rd_tag_lit", 64'(cap_t), 64'h1105);

    read_txn(64'h9F, 8'h05, na, lat);
    for (int b = 0; b < 8; b++) chk("rd_offset_ignored", cap_d[b], 64'h200 + 64'(b));

    ack_mode = 1;
    read_txn(64'h80, 8'h15, na, lat);
    chk("rd_stall_beats", 64'(cap_n), 64'd8);
    chk("rd_stall_last", cap_d[7], 64'h207);
    ack_mode = 0;

    for (int b = 0; b < 8; b++) d[b] = 64'hA0 + 64'(b);
    write_txn(64'h40, 8'h06, d, 3, 2);
    lines.push_back(1);
    chk("wr_done_beats", 64'(cap_n), 64'd1);
    chk("wr_done_data", cap_d[0], 64'd0);
    chk("wr_done_tag", 64'(cap_t), 64'h0106);
    read_txn(64'h40, 8'h08, na, lat);
    for (int b = 0; b < 8; b++) chk("wr_readback_lit", cap_d[b], 64'hA0 + 64'(b));

    // Second command held while a stalled read is in flight.
    ack_mode = 1;
    cap_n = 0;
    do_cmd(1'b1, 64'h80, 8'h09, 4'h1, na, qa);
    for (int b = 0; b < 8; b++) exp_q.push_back('{d: exp_rd(64'h80, b), t: exp_tag(1'b1, 8'h09, 64'h80)});
    do_cmd(1'b1, 64'h40, 8'h0A, 4'h1, na, qa);
    chk("held_ack_after_first", 64'(qa), 64'd0);
    chk("held_first_beats", 64'(cap_n), 64'd8);
    for (int b = 0; b < 8; b++) exp_q.push_back('{d: exp_rd(64'h40, b), t: exp_tag(1'b1, 8'h0A, 64'h40)});
    drain();
    ack_mode = 0;

    req_reqcyc = 1'b1;
    req_req    = 64'h80;
    req_reqtag = {1'b1, 4'h2, 8'h33};
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (reqack || resp_respcyc) seen++;
    end
    chk("foreign_target_ignored", 64'(seen), 64'd0);
    req_reqcyc = 1'b0;
    @(posedge clk);
    #1;

    // Reset asserted while beat 3 of a read is on the bus.
    cap_n = 0;
    do_cmd(1'b1, 64'h80, 8'h0B, 4'h1, na, qa);
    for (int b = 0; b < 8; b++) exp_q.push_back('{d: exp_rd(64'h80, b), t: exp_tag(1'b1, 8'h0B, 64'h80)});
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_rst_at_beat3", 64'(cap_n), 64'd3);
    chk("mid_rst_respcyc_before", 64'(resp_respcyc), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_respcyc", 64'(resp_respcyc), 64'd0);
    chk("mid_rst_reqack", 64'(reqack), 64'd0);
    chk("mid_rst_resp", resp_resp, 64'd0);
    chk("mid_rst_tag", 64'(resp_resptag), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    read_txn(64'h80, 8'h0C, na, lat);
    chk("post_rst_ack_delay", 64'(na), 64'd1);
    for (int b = 0; b < 8; b++) chk("post_rst_data", cap_d[b], 64'h200 + 64'(b));

    read_txn(64'h10000, 8'h07, na, lat);
`ifdef MUSK_MEM_BOUNDS_CHECK_EN
    for (int b = 0; b < 8; b++) chk("oob_data", cap_d[b], 64'hDEAD_BEEF_DEAD_BEEF);
    chk("oob_tag", 64'(cap_t), 64'h0107);
`else
    for (int b = 0; b < 8; b++) chk("wrap_data", cap_d[b], 64'h300 + 64'(b));
    chk("wrap_tag", 64'(cap_t), 64'h1107);
`endif

    ack_mode = 2;
    for (int t = 0; t < 40; t++) begin
      logic [63:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(1, 255)) : 64'd0;
      if ($urandom_range(0, 1) == 1) begin
        idx  = int'($urandom_range(0, MEM_LINES - 1));
        addr = (hi << 16) | (64'(idx) << 6) | 64'($urandom_range(0, 63));
        for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
        write_txn(addr, 8'($urandom), d, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        if (!is_oob(addr)) lines.push_back(idx);
      end else begin
        idx  = lines[$urandom_range(0, lines.size() - 1)];
        addr = (hi << 16) | (64'(idx) << 6) | 64'($urandom_range(0, 63));
        read_txn(addr, 8'($urandom), na, lat);
        chk("rand_rd_beats", 64'(cap_n), 64'd8);
      end
    end
    ack_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
